dmod_seg_mc: RTL and testbench
==============================

DMOD_SEG_MC -- requirements
Module: dmod_seg_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 12, number of demodulation windows (channels).
REQ-002 SHALL have parameter DATA_W, default 12, signed width of each mixed I/Q sample.
REQ-003 SHALL have parameter WIN_W, default 15, width of window start/length fields.
REQ-004 SHALL have parameter ACC_W, default 32, signed accumulator width; ACC_W >= DATA_W+WIN_W+1 is a legal-configuration rule.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port posedge_sample_trig  input  1  one-cycle acquisition start pulse.
REQ-008 SHALL have port cmd_smpl_depth  input  16  number of samples per acquisition.
REQ-009 SHALL have port smpl_valid  input  1  sample qualifier.
REQ-010 SHALL have port smpl_i / smpl_q  input  DATA_W each  signed mixed I and Q samples.
REQ-011 SHALL have port ch_en  input  NUM_CH  per-channel enable, bit k = channel k.
REQ-012 SHALL have port demo_win_start / demo_win_len  input  NUM_CH*WIN_W each  packed per-channel window start index and length, channel k at bits [k*WIN_W +: WIN_W].
REQ-013 SHALL have port fifo_full  input  1  downstream FIFO backpressure.
REQ-014 SHALL have port pstprc_iq_o  output  2*ACC_W  result word {I_acc, Q_acc}.
REQ-015 SHALL have port pstprc_ch_o  output  4  channel index of current word (clog2(NUM_CH) bits, min 1).
REQ-016 SHALL have port pstprc_fifo_wren  output  1  result-word write strobe.
REQ-017 SHALL have port Pstprc_finish  output  1  one-cycle end-of-acquisition pulse.
REQ-018 SHALL have ports busy and trig_miss  output  1 each  state not IDLE; sticky ignored-trigger flag.

Function
REQ-019 SHALL implement states IDLE, ACQ, DRAIN, DONE.
REQ-020 IDLE: on posedge_sample_trig SHALL latch cmd_smpl_depth, ch_en, all windows; clear all accumulators and sample counter; clear trig_miss; go ACQ (depth 0: go DRAIN directly).
REQ-021 ACQ: each cycle with smpl_valid=1 SHALL count sample index n (0..depth-1); smpl_valid=0 cycles neither count nor accumulate.
REQ-022 For each enabled channel k, sample n SHALL be added (sign-extended) to I_acc[k], Q_acc[k] iff start_k <= n < start_k+len_k, comparison in WIN_W+1 bits (no wrap).
REQ-023 Windows overlapping each other SHALL each accumulate independently; window portions beyond depth-1 SHALL be ignored; len 0 yields zero result.
REQ-024 After accepting sample depth-1, SHALL go DRAIN next cycle.
REQ-025 DRAIN: SHALL emit one word per cycle for enabled channels in ascending index, skipping disabled channels at zero cost; wren only when fifo_full=0.
REQ-026 While fifo_full=1, wren SHALL be 0 and pstprc_iq_o/pstprc_ch_o SHALL hold; emission resumes the cycle after fifo_full falls.
REQ-027 Latency: with fifo_full=0, first wren SHALL assert exactly 2 cycles after final sample accepted; words back-to-back thereafter.
REQ-028 After last enabled word (or immediately if ch_en latched 0), SHALL enter DONE, assert Pstprc_finish one cycle, return IDLE.
REQ-029 posedge_sample_trig in ACQ, DRAIN or DONE SHALL be ignored and set trig_miss; trigger coinciding with Pstprc_finish is ignored.
REQ-030 Input changes to ch_en/windows/depth during ACQ/DRAIN SHALL not affect the running acquisition.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, zero accumulators/counter, and drive pstprc_iq_o=0, pstprc_ch_o=0, pstprc_fifo_wren=0, Pstprc_finish=0, busy=0, trig_miss=0.
REQ-032 Reset mid-ACQ or mid-DRAIN SHALL abort with no further wren or finish; next trigger after release starts cleanly.

Verification
REQ-033 Depth 2000, ch0 start 0 len 1500, smpl_i=+1, smpl_q=-1 constant -> one word, ch 0, I=1500, Q=-1500, finish 1 cycle after wren.
REQ-034 ch_en=0x005, ch0 [10,20), ch2 [15,25), depth 30, ramp n -> words ch0 I=145, ch2 I=195, no ch1 word.
REQ-035 Window start 1990 len 100, depth 2000, I=+2 -> I=20 (clipped at depth).
REQ-036 fifo_full high 5 cycles mid-DRAIN of 12 channels -> 12 wrens total, no duplicates/loss, data held during stall.
REQ-037 Second trigger during ACQ -> ignored, trig_miss=1, results unchanged; next IDLE trigger clears trig_miss.
REQ-038 rst_n low 1 cycle mid-ACQ -> all outputs 0, no finish; fresh acquisition then produces correct results.

Source files
------------

// File: rtl/dmod_seg_mc_if.sv
// Result-word bus from the demodulator toward the post-processing FIFO.
// The FIFO side drives fifo_full back as backpressure.
interface dmod_seg_mc_if #(
    parameter int ACC_W = 32,
    parameter int CH_W  = 4
);
    logic [2*ACC_W-1:0] pstprc_iq_o;
    logic [CH_W-1:0]    pstprc_ch_o;
    logic               pstprc_fifo_wren;
    logic               fifo_full;

    modport master (
        output pstprc_iq_o,
        output pstprc_ch_o,
        output pstprc_fifo_wren,
        input  fifo_full
    );

    modport slave (
        input  pstprc_iq_o,
        input  pstprc_ch_o,
        input  pstprc_fifo_wren,
        output fifo_full
    );
endinterface

// File: rtl/dmod_seg_mc.sv
// Multi-channel segmented I/Q demodulator: per-channel sample windows
// are summed over one acquisition, then drained one word per cycle.
module dmod_seg_mc #(
    parameter int NUM_CH = 12,
    parameter int DATA_W = 12,
    parameter int WIN_W  = 15,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     posedge_sample_trig,
    input  logic [15:0]              cmd_smpl_depth,
    input  logic                     smpl_valid,
    input  logic signed [DATA_W-1:0] smpl_i,
    input  logic signed [DATA_W-1:0] smpl_q,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH*WIN_W-1:0]  demo_win_start,
    input  logic [NUM_CH*WIN_W-1:0]  demo_win_len,
    dmod_seg_mc_if.master            res,
    output logic                     Pstprc_finish,
    output logic                     busy,
    output logic                     trig_miss
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CMP_W = (WIN_W + 1 > 16) ? WIN_W + 1 : 16;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        DRAIN,
        DONE
    } state_t;

    state_t                   state_q;
    logic [15:0]              depth_q;
    logic [15:0]              cnt_q;
    logic [NUM_CH-1:0]        en_q;
    logic [NUM_CH-1:0]        pend_q;
    logic [WIN_W-1:0]         start_q [NUM_CH];
    logic [WIN_W-1:0]         len_q   [NUM_CH];
    logic signed [ACC_W-1:0]  acc_i_q [NUM_CH];
    logic signed [ACC_W-1:0]  acc_q_q [NUM_CH];
    logic [2*ACC_W-1:0]       iq_q;
    logic [CH_W-1:0]          ch_q;
    logic                     wren_q;
    logic                     fin_q;
    logic                     miss_q;

    logic [15:0]              cnt_d;
    logic [CMP_W-1:0]         n_ext;
    logic [NUM_CH-1:0]        hit;
    logic [NUM_CH-1:0]        sel_oh;
    logic [NUM_CH-1:0]        pend_d;
    logic [CH_W-1:0]          sel_idx;
    logic signed [ACC_W-1:0]  si_x;
    logic signed [ACC_W-1:0]  sq_x;

    assign cnt_d = cnt_q + 16'd1;
    assign n_ext = CMP_W'(cnt_q);
    assign si_x  = {{(ACC_W-DATA_W){smpl_i[DATA_W-1]}}, smpl_i};
    assign sq_x  = {{(ACC_W-DATA_W){smpl_q[DATA_W-1]}}, smpl_q};

    // Window bounds are widened so start+len never wraps.
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hit[k] = en_q[k]
                && (n_ext >= CMP_W'(start_q[k]))
                && (n_ext <  CMP_W'(start_q[k]) + CMP_W'(len_q[k]));
        end
    end

    // Lowest pending channel is emitted next; disabled ones never appear.
    assign sel_oh = pend_q & (~pend_q + NUM_CH'(1));
    assign pend_d = pend_q & ~sel_oh;

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_oh[k]) sel_idx = CH_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            depth_q <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            pend_q  <= '0;
            iq_q    <= '0;
            ch_q    <= '0;
            wren_q  <= 1'b0;
            fin_q   <= 1'b0;
            miss_q  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                start_q[k] <= '0;
                len_q[k]   <= '0;
                acc_i_q[k] <= '0;
                acc_q_q[k] <= '0;
            end
        end else begin
            fin_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    wren_q <= 1'b0;
                    if (posedge_sample_trig) begin
                        // A trigger landing on the finish pulse is a miss.
                        if (fin_q) begin
                            miss_q <= 1'b1;
                        end else begin
                            miss_q  <= 1'b0;
                            depth_q <= cmd_smpl_depth;
                            en_q    <= ch_en;
                            pend_q  <= ch_en;
                            cnt_q   <= '0;
                            for (int k = 0; k < NUM_CH; k++) begin
                                start_q[k] <= demo_win_start[k*WIN_W +: WIN_W];
                                len_q[k]   <= demo_win_len[k*WIN_W +: WIN_W];
                                acc_i_q[k] <= '0;
                                acc_q_q[k] <= '0;
                            end
                            state_q <= (cmd_smpl_depth == 16'd0) ? DRAIN : ACQ;
                        end
                    end
                end
                ACQ: begin
                    if (posedge_sample_trig) miss_q <= 1'b1;
                    if (smpl_valid) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (hit[k]) begin
                                acc_i_q[k] <= acc_i_q[k] + si_x;
                                acc_q_q[k] <= acc_q_q[k] + sq_x;
                            end
                        end
                        cnt_q <= cnt_d;
                        if (cnt_d == depth_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (posedge_sample_trig) miss_q <= 1'b1;
                    if (pend_q == '0) begin
                        wren_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (res.fifo_full) begin
                        wren_q <= 1'b0;
                    end else begin
                        wren_q <= 1'b1;
                        iq_q   <= {acc_i_q[sel_idx], acc_q_q[sel_idx]};
                        ch_q   <= sel_idx;
                        pend_q <= pend_d;
                        if (pend_d == '0) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (posedge_sample_trig) miss_q <= 1'b1;
                    wren_q  <= 1'b0;
                    fin_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res.pstprc_iq_o      = iq_q;
    assign res.pstprc_ch_o      = ch_q;
    assign res.pstprc_fifo_wren = wren_q;
    assign Pstprc_finish        = fin_q;
    assign busy                 = (state_q != IDLE);
    assign trig_miss            = miss_q;

endmodule

// File: tb/tb_dmod_seg_mc.sv
// Scoreboard bench for dmod_seg_mc: directed acquisitions push expected
// result words; a negedge monitor pops and compares each written word.
module tb_dmod_seg_mc;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                posedge_sample_trig;
    logic [15:0]         cmd_smpl_depth;
    logic                smpl_valid;
    logic signed [11:0]  smpl_i;
    logic signed [11:0]  smpl_q;
    logic [11:0]         ch_en;
    logic [179:0]        demo_win_start;
    logic [179:0]        demo_win_len;
    logic                Pstprc_finish;
    logic                busy;
    logic                trig_miss;

    dmod_seg_mc_if #(.ACC_W(32), .CH_W(4)) bus ();

    dmod_seg_mc #(
        .NUM_CH(12), .DATA_W(12), .WIN_W(15), .ACC_W(32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .posedge_sample_trig(posedge_sample_trig),
        .cmd_smpl_depth     (cmd_smpl_depth),
        .smpl_valid         (smpl_valid),
        .smpl_i             (smpl_i),
        .smpl_q             (smpl_q),
        .ch_en              (ch_en),
        .demo_win_start     (demo_win_start),
        .demo_win_len       (demo_win_len),
        .res                (bus),
        .Pstprc_finish      (Pstprc_finish),
        .busy               (busy),
        .trig_miss          (trig_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        longint i;
        longint q;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   last_exp;
    bit     have_last;
    int     checks;
    int     errors;
    int     cyc;
    int     lat_ref;
    bit     lat_arm;
    bit     stall_chk;
    int     fin_exp;
    int     fin_cnt;
    int     words_acq;
    int     last_wren_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pstprc_fifo_wren) begin
                longint gi;
                longint gq;
                exp_t   e;
                gi = longint'($signed(bus.pstprc_iq_o[63:32]));
                gq = longint'($signed(bus.pstprc_iq_o[31:0]));
                if (lat_arm) begin
                    chk(cyc == lat_ref + 2, "first_wren_latency",
                        cyc - lat_ref, 2);
                    lat_arm = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_word_ch",
                        longint'(bus.pstprc_ch_o), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk(int'(bus.pstprc_ch_o) == e.ch, "word_ch",
                        longint'(bus.pstprc_ch_o), e.ch);
                    chk(gi == e.i, "word_I", gi, e.i);
                    chk(gq == e.q, "word_Q", gq, e.q);
                    last_exp  = e;
                    have_last = 1'b1;
                end
                words_acq++;
                last_wren_cyc = cyc;
            end else if (stall_chk && have_last) begin
                chk(int'(bus.pstprc_ch_o) == last_exp.ch, "stall_hold_ch",
                    longint'(bus.pstprc_ch_o), last_exp.ch);
                chk(longint'($signed(bus.pstprc_iq_o[63:32])) == last_exp.i,
                    "stall_hold_I",
                    longint'($signed(bus.pstprc_iq_o[63:32])), last_exp.i);
            end
            if (Pstprc_finish) begin
                chk(fin_exp > 0, "finish_expected", 1, fin_exp);
                if (fin_exp > 0) fin_exp--;
                chk(exp_q.size() == 0, "words_left_at_finish",
                    exp_q.size(), 0);
                if (words_acq > 0)
                    chk(cyc == last_wren_cyc + 1, "finish_after_wren",
                        cyc - last_wren_cyc, 1);
                fin_cnt++;
            end
        end
    end

    function automatic logic signed [11:0] fi(input int mode, input int n);
        case (mode)
            0: return 12'sd1;
            1: return 12'(n);
            2: return 12'sd2;
            3: return 12'(n + 1);
            4: return 12'sd7;
            default: return 12'sd5;
        endcase
    endfunction

    function automatic logic signed [11:0] fq(input int mode, input int n);
        case (mode)
            0: return -12'sd1;
            1: return 12'(-n);
            2: return 12'sd3;
            3: return 12'(-2 * (n + 1));
            4: return -12'sd4;
            default: return -12'sd5;
        endcase
    endfunction

    task automatic push(input int ch, input longint i, input longint q);
        exp_t e;
        e.ch = ch; e.i = i; e.q = q;
        exp_q.push_back(e);
    endtask

    task automatic set_win(input int k, input int s, input int l);
        demo_win_start[k*15 +: 15] = 15'(s);
        demo_win_len[k*15 +: 15]   = 15'(l);
    endtask

    task automatic start_acq(input int depth, input logic [11:0] en);
        @(posedge clk); #1;
        cmd_smpl_depth      = 16'(depth);
        ch_en               = en;
        posedge_sample_trig = 1'b1;
        words_acq           = 0;
        have_last           = 1'b0;
        @(posedge clk); #1;
        posedge_sample_trig = 1'b0;
    endtask

    task automatic feed(input int depth, input int mode,
                        input bit gaps, input int stray_at);
        for (int n = 0; n < depth; n++) begin
            if (gaps && (n % 4 == 1)) begin
                smpl_valid = 1'b0;
                smpl_i     = 12'sh7ff;
                smpl_q     = 12'sh7ff;
                @(posedge clk); #1;
            end
            smpl_valid          = 1'b1;
            smpl_i              = fi(mode, n);
            smpl_q              = fq(mode, n);
            posedge_sample_trig = (n == stray_at);
            if (n == depth - 1) begin
                lat_ref = cyc;
                lat_arm = 1'b1;
            end
            @(posedge clk); #1;
        end
        smpl_valid          = 1'b0;
        posedge_sample_trig = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int f0;
        int k;
        f0 = fin_cnt;
        k  = 0;
        while (fin_cnt == f0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (fin_cnt == f0) chk(1'b0, "finish_timeout", k, budget);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; posedge_sample_trig = 1'b0; cmd_smpl_depth = '0;
        smpl_valid = 1'b0; smpl_i = '0; smpl_q = '0; ch_en = '0;
        demo_win_start = '0; demo_win_len = '0; bus.fifo_full = 1'b0;
        checks = 0; errors = 0; cyc = 0; lat_arm = 1'b0; stall_chk = 1'b0;
        fin_exp = 0; fin_cnt = 0; words_acq = 0; have_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk(bus.pstprc_iq_o == 0, "reset_iq", longint'(bus.pstprc_iq_o), 0);
        chk(bus.pstprc_ch_o == 0, "reset_ch", longint'(bus.pstprc_ch_o), 0);
        chk(!bus.pstprc_fifo_wren, "reset_wren", bus.pstprc_fifo_wren, 0);
        chk(!Pstprc_finish, "reset_finish", Pstprc_finish, 0);
        chk(!busy, "reset_busy", busy, 0);
        chk(!trig_miss, "reset_trig_miss", trig_miss, 0);

        // Single long window, constant samples
        set_win(0, 0, 1500);
        push(0, 1500, -1500); fin_exp++;
        start_acq(2000, 12'h001);
        feed(2000, 0, 1'b0, -1);
        wait_finish(50);

        // Two windows, ramp, gaps; config scrambled after trigger
        demo_win_start = '0; demo_win_len = '0;
        set_win(0, 10, 10); set_win(1, 0, 30); set_win(2, 15, 10);
        push(0, 145, -145); push(2, 195, -195); fin_exp++;
        start_acq(30, 12'h005);
        ch_en = 12'hfff; cmd_smpl_depth = 16'd3;
        demo_win_start = '1; demo_win_len = '1;
        feed(30, 1, 1'b1, -1);
        wait_finish(50);

        // Window running past the end of the acquisition
        demo_win_start = '0; demo_win_len = '0;
        set_win(0, 1990, 100);
        push(0, 20, 30); fin_exp++;
        start_acq(2000, 12'h001);
        feed(2000, 2, 1'b0, -1);
        wait_finish(50);

        // All 12 channels, backpressure mid-drain
        demo_win_start = '0; demo_win_len = '0;
        for (int k = 0; k < 12; k++) begin
            longint si;
            longint sq;
            int     l;
            l  = (k == 0) ? 0 : k + 1;
            si = 0; sq = 0;
            set_win(k, k, l);
            for (int n = 0; n < 12; n++) begin
                if (n >= k && n < k + l) begin
                    si += n + 1;
                    sq += -2 * (n + 1);
                end
            end
            push(k, si, sq);
        end
        fin_exp++;
        start_acq(12, 12'hfff);
        feed(12, 3, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1 bus.fifo_full = 1'b1; stall_chk = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.fifo_full = 1'b0; stall_chk = 1'b0;
        wait_finish(50);
        chk(words_acq == 12, "stall_word_count", words_acq, 12);

        // Stray trigger during acquisition
        demo_win_start = '0; demo_win_len = '0;
        set_win(3, 2, 3);
        push(3, 21, -12); fin_exp++;
        start_acq(10, 12'h008);
        feed(10, 4, 1'b0, 4);
        wait_finish(50);
        chk(trig_miss, "trig_miss_sticky", trig_miss, 1);

        // Depth 0: enabled channels drain zero words; trigger clears miss
        push(0, 0, 0); push(1, 0, 0); fin_exp++;
        start_acq(0, 12'h003);
        @(negedge clk);
        chk(!trig_miss, "trig_miss_cleared", trig_miss, 0);
        wait_finish(50);

        // No channels enabled; trigger on the finish pulse is ignored
        fin_exp++;
        start_acq(0, 12'h000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        posedge_sample_trig = 1'b1;
        @(posedge clk); #1;
        posedge_sample_trig = 1'b0;
        @(negedge clk);
        chk(!busy, "finish_trig_ignored_busy", busy, 0);
        chk(trig_miss, "finish_trig_miss", trig_miss, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk(!busy, "finish_trig_still_idle", busy, 0);
        chk(fin_exp == 0, "finish_pending", fin_exp, 0);

        // Reset mid-acquisition aborts cleanly
        demo_win_start = '0; demo_win_len = '0;
        set_win(0, 0, 20);
        start_acq(20, 12'h001);
        for (int n = 0; n < 10; n++) begin
            smpl_valid = 1'b1; smpl_i = 12'sd9; smpl_q = 12'sd9;
            @(posedge clk); #1;
        end
        smpl_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk(bus.pstprc_iq_o == 0, "rst_mid_iq", longint'(bus.pstprc_iq_o), 0);
        chk(bus.pstprc_ch_o == 0, "rst_mid_ch", longint'(bus.pstprc_ch_o), 0);
        chk(!bus.pstprc_fifo_wren, "rst_mid_wren", bus.pstprc_fifo_wren, 0);
        chk(!Pstprc_finish, "rst_mid_finish", Pstprc_finish, 0);
        chk(!busy, "rst_mid_busy", busy, 0);
        chk(!trig_miss, "rst_mid_trig_miss", trig_miss, 0);
        repeat (30) @(posedge clk);
        #1;
        demo_win_start = '0; demo_win_len = '0;
        set_win(0, 0, 8);
        push(0, 40, -40); fin_exp++;
        start_acq(8, 12'h001);
        feed(8, 5, 1'b0, -1);
        wait_finish(50);

        repeat (5) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        chk(fin_exp == 0, "finish_all_seen", fin_exp, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
